multi_clock_divider: RTL
========================

# multi_clock_divider

Parametrised, multi-channel successor to the single-output fixed clock divider. It produces CHANNELS independent divided clock-enable waveforms from one system clock. Each channel has a runtime-programmable period and high time, an enable, and a one-cycle tick at each period start. Configuration changes are glitch-free, and a common sync input phase-aligns all channels. It sits between the system clock and peripherals that need slow strobes or square waves, such as UART baud, LED PWM and sampling ticks.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16)
- COUNT_WIDTH, 16: counter, DIV and HIGH width in bits
- DEFAULT_DIV, 5: reset period minus one, applied to every channel (period = DIV+1 cycles)
- DEFAULT_HIGH, 3: reset high time in cycles, applied to every channel
- CH_W, derived: max(1, clog2(CHANNELS))

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  CHANNELS  per-channel run enable
- sync  in  1  single-cycle pulse; forces every enabled channel to restart its period
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted this cycle
- cfg_ch  in  CH_W  target channel
- cfg_div  in  COUNT_WIDTH  new period minus one
- cfg_high  in  COUNT_WIDTH  new high time in cycles
- out  out  CHANNELS  registered divided waveform per channel
- tick  out  CHANNELS  registered one-cycle pulse, high in the first cycle of each period

## Operation
- Per-channel state: counter cnt, active DIV/HIGH, shadow DIV/HIGH, pending flag, previous enable.
- Wrap event on a channel at an edge when any of these holds while en=1:
  - cnt==DIV
  - en was 0 on the previous edge (rising enable)
  - sync=1
- On a wrap: cnt<=0. If pending, active<=shadow and pending<=0. The new active values govern this new period.
- Otherwise, while en=1: cnt<=cnt+1.
- Output rule, evaluated on the next cnt with the active values in force after the edge:
  - out<=(next_cnt<HIGH)
  - tick<=wrap
- Disabled channel (en=0): cnt<=0, out<=0, tick<=0. Sync has no effect.
- Config handshake:
  - A write is accepted at an edge when cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch]. It is combinational from cfg_ch and pending.
  - cfg_ch>=CHANNELS: cfg_ready=1; the write is accepted and discarded.
- Accepted write to an enabled channel: shadow<=cfg_div/cfg_high and pending<=1. It applies at the channel's next wrap. A wrap on the same edge as acceptance does not consume it.
- Accepted write to a disabled channel: active registers are written directly; pending stays 0.
- Arithmetic and boundary values:
  - Comparisons are unsigned, COUNT_WIDTH wide.
  - HIGH=0 gives out constant 0.
  - HIGH>DIV gives out constant 1 while enabled.
  - DIV=0 gives period 1, tick high every enabled cycle.
- Simultaneous events:
  - Sync on the same edge as a natural wrap counts as a single wrap (one tick).
  - Sync on the same edge as a rising enable counts as a single wrap.

## Timing
- Reset values:
  - cnt=0, active DIV=DEFAULT_DIV, active HIGH=DEFAULT_HIGH, shadows equal the actives
  - pending=0, out=0, tick=0, cfg_ready=1
- Reset mid-operation returns every channel to the reset values next edge and discards pending writes.
- Enable latency: en sampled high at edge k → out=(0<HIGH) and tick=1 in the cycle after edge k.
- Disable latency: en sampled low at edge k → out=0 after edge k.
- Sync latency: sync sampled at edge k → tick=1 and period restart after edge k for all enabled channels.
- Config apply latency: a write accepted at edge k, with channel wrap at edge m>k, takes effect in the period starting after edge m.
- cfg_ready for that channel is 0 from the cycle after edge k through edge m, then returns to 1.
- Steady state: out is high HIGH cycles then low DIV+1-HIGH cycles. tick has period DIV+1 and is coincident with each out rise when HIGH>0.

## Test plan
- Reset, then en=4'b0001 with defaults → ch0 out pattern 111000 repeating, tick every 6 cycles coincident with the out rise; other channels out=0 and tick=0.
- With ch0 running, write cfg_ch=0, div=9, high=2 mid-period → current 6-cycle period completes unchanged, then pattern 1100000000; cfg_ready low from accept until that wrap; a second cfg_valid during the wait is not accepted.
- ch1 disabled, write div=3, high=1, then enable → first period is already 1000, with tick in the first enabled output cycle.
- Channels 0-2 enabled with differing DIV, sync pulsed once → all three tick in the same cycle after sync and restart with out=1.
- Boundary values: HIGH=0 gives out constant 0; HIGH=20 with DIV=9 gives out constant 1; DIV=0, HIGH=1 gives tick and out high every cycle. A write with cfg_ch=7 when CHANNELS=4 is accepted and leaves all channels unchanged.
- Assert rst mid-period with a write pending → next cycle all out and tick are 0, cfg_ready=1. After re-enable, behaviour matches the defaults and the pending write is never applied.

Source files
------------

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock-enable divider: each channel produces a
// square wave and a period-start tick, with glitch-free shadowed reconfiguration.
module multi_clock_divider #(
  parameter int CHANNELS     = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter int DEFAULT_DIV  = 5,
  parameter int DEFAULT_HIGH = 3,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    en,
  input  logic                   sync,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [COUNT_WIDTH-1:0] cfg_div,
  input  logic [COUNT_WIDTH-1:0] cfg_high,
  output logic [CHANNELS-1:0]    out,
  output logic [CHANNELS-1:0]    tick
);

  localparam logic [COUNT_WIDTH-1:0] RST_DIV  = COUNT_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNT_WIDTH-1:0] RST_HIGH = COUNT_WIDTH'(DEFAULT_HIGH);
  localparam logic [COUNT_WIDTH-1:0] ZERO     = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] cnt_r     [CHANNELS];
  logic [COUNT_WIDTH-1:0] div_r     [CHANNELS];
  logic [COUNT_WIDTH-1:0] high_r    [CHANNELS];
  logic [COUNT_WIDTH-1:0] sh_div_r  [CHANNELS];
  logic [COUNT_WIDTH-1:0] sh_high_r [CHANNELS];
  logic [CHANNELS-1:0]    pending_r;
  logic [CHANNELS-1:0]    en_prev_r;

  logic [COUNT_WIDTH-1:0] next_cnt_s  [CHANNELS];
  logic [COUNT_WIDTH-1:0] next_div_s  [CHANNELS];
  logic [COUNT_WIDTH-1:0] next_high_s [CHANNELS];
  logic [CHANNELS-1:0]    sel_s;
  logic [CHANNELS-1:0]    wrap_s;
  logic [CHANNELS-1:0]    apply_s;
  logic [CHANNELS-1:0]    wr_hit_s;
  logic                   accept_s;

  // Wrap detection, pending-config selection and the config handshake.
  // An out-of-range cfg_ch selects no channel, so it is always ready and discarded.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sel_s[i]       = (cfg_ch == CH_W'(i));
      wrap_s[i]      = en[i] & ((cnt_r[i] == div_r[i]) | ~en_prev_r[i] | sync);
      apply_s[i]     = wrap_s[i] & pending_r[i];
      next_div_s[i]  = apply_s[i] ? sh_div_r[i]  : div_r[i];
      next_high_s[i] = apply_s[i] ? sh_high_r[i] : high_r[i];
      next_cnt_s[i]  = wrap_s[i]  ? ZERO         : cnt_r[i] + ONE;
    end
    cfg_ready = ~|(sel_s & pending_r);
    accept_s  = cfg_valid & cfg_ready;
    wr_hit_s  = sel_s & {CHANNELS{accept_s}};
  end

  // Per-channel counters, active/shadow configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {CHANNELS{1'b0}};
      en_prev_r <= {CHANNELS{1'b0}};
      out       <= {CHANNELS{1'b0}};
      tick      <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i]     <= ZERO;
        div_r[i]     <= RST_DIV;
        high_r[i]    <= RST_HIGH;
        sh_div_r[i]  <= RST_DIV;
        sh_high_r[i] <= RST_HIGH;
      end
    end else begin
      en_prev_r <= en;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!en[i]) begin
          cnt_r[i] <= ZERO;
          out[i]   <= 1'b0;
          tick[i]  <= 1'b0;
          // An idle channel has no period in flight, so the write goes live at once.
          if (wr_hit_s[i]) begin
            div_r[i]     <= cfg_div;
            high_r[i]    <= cfg_high;
            sh_div_r[i]  <= cfg_div;
            sh_high_r[i] <= cfg_high;
          end else begin
            div_r[i]  <= div_r[i];
            high_r[i] <= high_r[i];
          end
        end else begin
          cnt_r[i]  <= next_cnt_s[i];
          div_r[i]  <= next_div_s[i];
          high_r[i] <= next_high_s[i];
          out[i]    <= (next_cnt_s[i] < next_high_s[i]);
          tick[i]   <= wrap_s[i];
          // Acceptance needs pending==0, so a same-edge wrap never consumes this write.
          if (wr_hit_s[i]) begin
            sh_div_r[i]  <= cfg_div;
            sh_high_r[i] <= cfg_high;
            pending_r[i] <= 1'b1;
          end else if (apply_s[i]) begin
            pending_r[i] <= 1'b0;
          end else begin
            pending_r[i] <= pending_r[i];
          end
        end
      end
    end
  end

endmodule
